// File: rtl/lock_pkg.sv
// Shared codes and session states for the two-panel keypad lock arbiter.
package lock_pkg;

  localparam logic [1:0] KEY_DIGIT   = 2'b00;
  localparam logic [1:0] KEY_CONFIRM = 2'b01;
  localparam logic [1:0] KEY_CANCEL  = 2'b10;

  localparam logic [1:0] RES_FAIL   = 2'b00;
  localparam logic [1:0] RES_UNLOCK = 2'b01;
  localparam logic [1:0] RES_RESET  = 2'b10;
  localparam logic [1:0] RES_LOCKED = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OWN      = 2'b01,
    WAIT_RES = 2'b10,
    REPORT   = 2'b11
  } state_t;

  // Lockout outranks password reset, which outranks a plain unlock.
  function automatic logic [1:0] res_code(input logic locking, input logic reset_ok,
                                          input logic unlock_ok);
    if (locking)        return RES_LOCKED;
    else if (reset_ok)  return RES_RESET;
    else if (unlock_ok) return RES_UNLOCK;
    else                return RES_FAIL;
  endfunction

endpackage

// File: rtl/lock_rr_arb2.sv
// Two-way round-robin picker: combinational grant, registered last-winner pointer.
module lock_rr_arb2 (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt_any,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_any = |req;
    if (&req) gnt_idx = ~last_q;
    else      gnt_idx = req[1];
  end

  // Reset to panel 1 so panel 0 takes the first tie.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b)              last_q <= 1'b1;
    else if (upd && gnt_any) last_q <= gnt_idx;
  end

endmodule

// File: rtl/lock_panel_arbiter.sv
// Session arbiter sharing one keypad lock core between two panels.
//
// state    | meaning
// IDLE     | no session; grant a requesting panel round-robin
// OWN      | owner's keys forwarded to the lock; inactivity timer running
// WAIT_RES | confirm sent; sticky-capture lock flags for RESP_WAIT cycles
// REPORT   | one-cycle result strobe to the owner
module lock_panel_arbiter
  import lock_pkg::*;
#(
  parameter int TIMEOUT   = 1000,
  parameter int RESP_WAIT = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] p_vld,
  output logic [1:0] p_rdy,
  input  logic [7:0] p_key,
  input  logic [3:0] p_type,
  output logic [1:0] p_res_vld,
  output logic [1:0] p_res_code,
  output logic       owner,
  output logic       busy,
  output logic [3:0] lk_din,
  output logic       lk_vld,
  output logic       lk_confirm,
  output logic       lk_cancel,
  input  logic       lk_unlock_ok,
  input  logic       lk_reset_ok,
  input  logic       lk_locking
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(RESP_WAIT + 1);
  localparam logic [TW-1:0] IDLE_TC = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RSP_TC  = RW'(RESP_WAIT - 1);

  state_t        state_q, state_d;
  logic          owner_q;
  logic [TW-1:0] idle_cnt_q;
  logic [RW-1:0] rsp_cnt_q;
  logic          cap_lock_q, cap_reset_q, cap_unlock_q;
  logic [3:0]    lk_din_q;
  logic          lk_vld_q, lk_confirm_q, lk_cancel_q;

  logic          gnt_any, gnt_idx;
  logic [3:0]    own_key;
  logic [1:0]    own_type;
  logic          accept, timeout_hit, window_sample, window_end;

  lock_rr_arb2 u_rr (
    .clk_sys (clk),
    .rst_b   (clr),
    .req     (p_vld),
    .upd     (state_q == IDLE),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // The first WAIT_RES cycle carries the confirm strobe itself; the window starts after it.
  always_comb begin
    own_key       = owner_q ? p_key[7:4] : p_key[3:0];
    own_type      = owner_q ? p_type[3:2] : p_type[1:0];
    accept        = (state_q == OWN) && p_vld[owner_q];
    timeout_hit   = (state_q == OWN) && !accept && (idle_cnt_q == IDLE_TC);
    window_sample = (state_q == WAIT_RES) && !lk_confirm_q;
    window_end    = window_sample && (rsp_cnt_q == RSP_TC);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_any) state_d = OWN;
      OWN: begin
        if (accept) begin
          if (own_type == KEY_CONFIRM)     state_d = WAIT_RES;
          else if (own_type == KEY_CANCEL) state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      WAIT_RES: if (window_end) state_d = REPORT;
      REPORT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    p_rdy      = 2'b00;
    p_res_vld  = 2'b00;
    p_res_code = RES_FAIL;
    busy       = (state_q != IDLE);
    if (state_q == OWN) p_rdy[owner_q] = 1'b1;
    if (state_q == REPORT) begin
      p_res_vld[owner_q] = 1'b1;
      p_res_code         = res_code(cap_lock_q, cap_reset_q, cap_unlock_q);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      idle_cnt_q   <= '0;
      rsp_cnt_q    <= '0;
      cap_lock_q   <= 1'b0;
      cap_reset_q  <= 1'b0;
      cap_unlock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_any) owner_q <= gnt_idx;

      if (state_q != OWN || accept)  idle_cnt_q <= '0;
      else if (idle_cnt_q != IDLE_TC) idle_cnt_q <= idle_cnt_q + 1'b1;

      if (state_q != WAIT_RES)                    rsp_cnt_q <= '0;
      else if (window_sample && rsp_cnt_q != RSP_TC) rsp_cnt_q <= rsp_cnt_q + 1'b1;

      if (state_q == IDLE || state_q == OWN) begin
        cap_lock_q   <= 1'b0;
        cap_reset_q  <= 1'b0;
        cap_unlock_q <= 1'b0;
      end else if (window_sample) begin
        cap_lock_q   <= cap_lock_q   | lk_locking;
        cap_reset_q  <= cap_reset_q  | lk_reset_ok;
        cap_unlock_q <= cap_unlock_q | lk_unlock_ok;
      end
    end
  end

  // Out-of-range digits and reserved key types are consumed but never reach the lock.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      lk_din_q     <= 4'd0;
      lk_vld_q     <= 1'b0;
      lk_confirm_q <= 1'b0;
      lk_cancel_q  <= 1'b0;
    end else begin
      lk_vld_q     <= 1'b0;
      lk_confirm_q <= 1'b0;
      lk_cancel_q  <= 1'b0;
      if (accept) begin
        case (own_type)
          KEY_DIGIT: begin
            if (own_key <= 4'd9) begin
              lk_din_q <= own_key;
              lk_vld_q <= 1'b1;
            end
          end
          KEY_CONFIRM: lk_confirm_q <= 1'b1;
          KEY_CANCEL:  lk_cancel_q  <= 1'b1;
          default:     ;
        endcase
      end else if (timeout_hit) begin
        lk_cancel_q <= 1'b1;
      end
    end
  end

  assign owner      = owner_q;
  assign lk_din     = lk_din_q;
  assign lk_vld     = lk_vld_q;
  assign lk_confirm = lk_confirm_q;
  assign lk_cancel  = lk_cancel_q;

endmodule

// File: tb/tb_lock_panel_arbiter.sv
// Randomised session-level bench for lock_panel_arbiter against a transaction model.
module tb_lock_panel_arbiter;
  import lock_pkg::*;

  localparam int TIMEOUT   = 16;
  localparam int RESP_WAIT = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] p_vld = '0;
  logic [1:0] p_rdy;
  logic [7:0] p_key = '0;
  logic [3:0] p_type = '0;
  logic [1:0] p_res_vld, p_res_code;
  logic       owner, busy;
  logic [3:0] lk_din;
  logic       lk_vld, lk_confirm, lk_cancel;
  logic       lk_unlock_ok = 1'b0, lk_reset_ok = 1'b0, lk_locking = 1'b0;

  lock_panel_arbiter #(.TIMEOUT(TIMEOUT), .RESP_WAIT(RESP_WAIT)) dut (
    .clk(clk), .clr(clr), .p_vld(p_vld), .p_rdy(p_rdy), .p_key(p_key), .p_type(p_type),
    .p_res_vld(p_res_vld), .p_res_code(p_res_code), .owner(owner), .busy(busy),
    .lk_din(lk_din), .lk_vld(lk_vld), .lk_confirm(lk_confirm), .lk_cancel(lk_cancel),
    .lk_unlock_ok(lk_unlock_ok), .lk_reset_ok(lk_reset_ok), .lk_locking(lk_locking)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, n_cancel = 0, n_res = 0, viol = 0;
  int         exp_nres = 0;
  int         last_m = 1;
  logic [3:0] got_q[$];
  int         got_cyc[$];
  logic [5:0] kq[$];
  logic [5:0] kq2[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Lock-side observer plus handshake/strobe invariants.
  always @(negedge clk) begin
    cyc++;
    if (lk_vld) begin
      got_q.push_back(lk_din);
      got_cyc.push_back(cyc);
    end
    if (lk_cancel) n_cancel++;
    if (|p_res_vld) n_res++;
    if (p_rdy == 2'b11 || (p_rdy != 2'b00 && (!busy || p_rdy != (2'b01 << owner)))) viol++;
    if ((int'(lk_vld) + int'(lk_confirm) + int'(lk_cancel)) > 1) viol++;
  end

  task automatic send_key(input int pn, input logic [3:0] key, input logic [1:0] typ,
                          output int waited);
    waited = 0;
    p_vld[pn] = 1'b1;
    p_key[4*pn +: 4] = key;
    p_type[2*pn +: 2] = typ;
    forever begin
      @(negedge clk);
      waited++;
      if (p_rdy[pn]) break;
      if (waited > 60) begin
        chk("hs_timeout", waited, 0);
        p_vld[pn] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    p_vld[pn] = 1'b0;
  endtask

  task automatic session(input int pn, input logic [5:0] keys[$], input bit end_cancel,
                         input logic [2:0] flg, input int k);
    logic [3:0] exp_q[$];
    int         w, lat;
    logic [1:0] vec, code, exp_code;
    got_q.delete();
    got_cyc.delete();
    foreach (keys[i]) begin
      send_key(pn, keys[i][3:0], keys[i][5:4], w);
      if (keys[i][5:4] == KEY_DIGIT && keys[i][3:0] <= 4'd9) exp_q.push_back(keys[i][3:0]);
    end
    if (end_cancel) begin
      send_key(pn, 4'd0, KEY_CANCEL, w);
      chk("owner", owner, pn);
      @(negedge clk);
      chk("cancel_strobe", lk_cancel, 1);
      chk("busy_after_cancel", busy, 0);
    end else begin
      send_key(pn, 4'd0, KEY_CONFIRM, w);
      chk("owner", owner, pn);
      exp_nres++;
      exp_code = flg[2] ? RES_LOCKED : flg[1] ? RES_RESET : flg[0] ? RES_UNLOCK : RES_FAIL;
      lat = -1; vec = 2'b00; code = 2'b00;
      fork
        begin
          repeat (k + 1) @(posedge clk);
          #1 {lk_locking, lk_reset_ok, lk_unlock_ok} = flg;
          @(posedge clk);
          #1 {lk_locking, lk_reset_ok, lk_unlock_ok} = 3'b000;
        end
        begin
          for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (|p_res_vld) begin
              lat = c; vec = p_res_vld; code = p_res_code;
              break;
            end
          end
        end
      join
      // confirm strobe cycle, RESP_WAIT window cycles, then the REPORT cycle
      chk("res_latency", lat, RESP_WAIT + 2);
      chk("res_vld", vec, 2'b01 << pn);
      chk("res_code", code, exp_code);
    end
    last_m = pn;
    chk("n_digits", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("digit", got_q[i], exp_q[i]);
    if (exp_q.size() > 1 && exp_q.size() == keys.size() && got_cyc.size() == exp_q.size())
      chk("digits_consecutive", got_cyc[got_cyc.size()-1] - got_cyc[0], exp_q.size() - 1);
  endtask

  task automatic do_reset();
    p_vld = '0;
    {lk_locking, lk_reset_ok, lk_unlock_ok} = 3'b000;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    last_m = 1;
  endtask

  task automatic rand_keys(input int held, output logic [5:0] q[$]);
    q.delete();
    if (held >= 0) q.push_back({KEY_DIGIT, 4'(held)});
    repeat ($urandom_range(0, 4)) begin
      if ($urandom_range(0, 7) == 0) q.push_back({2'b11, 4'($urandom_range(0, 15))});
      else                           q.push_back({KEY_DIGIT, 4'($urandom_range(0, 15))});
    end
  endtask

  initial begin
    int w, gap, c0, win, h0, h1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {p_rdy, p_res_vld, p_res_code, owner, busy, lk_din, lk_vld,
                          lk_confirm, lk_cancel}, 0);
    clr = 1'b1;

    // Panel 0: 1,2,3,4,# with unlock one cycle after confirm.
    kq = '{6'd1, 6'd2, 6'd3, 6'd4};
    session(0, kq, 1'b0, 3'b001, 0);

    // Simultaneous requests from reset: panel 0 first, panel 1's held keys intact.
    do_reset();
    p_key = {4'd6, 4'd5};
    p_type = '0;
    p_vld = 2'b11;
    kq = '{6'd5};
    session(0, kq, 1'b0, 3'b000, 1);
    kq = '{6'd6, 6'd7, 6'd8, 6'd9};
    session(1, kq, 1'b0, 3'b101, 2);

    // Panel 1 cancels; panel 0 is granted on the following cycle and then times out.
    kq = '{6'd6, 6'd7, 6'd8};
    session(1, kq, 1'b1, 3'b000, 0);
    got_q.delete();
    got_cyc.delete();
    p_key[3:0] = 4'd1;
    p_type[1:0] = KEY_DIGIT;
    p_vld[0] = 1'b1;
    send_key(0, 4'd1, KEY_DIGIT, w);
    chk("grant_next_cycle", w, 1);
    c0 = n_cancel;
    gap = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (lk_cancel) begin gap = c; break; end
    end
    // digit strobe lands one cycle after the key, forced cancel TIMEOUT cycles after that
    chk("timeout_cycle", gap, TIMEOUT + 1);
    repeat (4) @(negedge clk);
    chk("timeout_cancels", n_cancel - c0, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_digits", got_q.size(), 1);
    last_m = 0;

    // Reset while waiting for the lock result.
    send_key(1, 4'd2, KEY_DIGIT, w);
    send_key(1, 4'd0, KEY_CONFIRM, w);
    repeat (2) @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("async_reset_outputs", {p_rdy, p_res_vld, p_res_code, busy, lk_din, lk_vld,
                                lk_confirm, lk_cancel}, 0);
    chk("async_reset_owner", owner, 0);
    @(posedge clk);
    #1 clr = 1'b1;
    last_m = 1;
    kq = '{6'd2};
    session(1, kq, 1'b0, 3'b010, 1);

    for (int s = 0; s < 14; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        h0 = $urandom_range(0, 9);
        h1 = $urandom_range(0, 9);
        p_key = {4'(h1), 4'(h0)};
        p_type = '0;
        p_vld = 2'b11;
        win = 1 - last_m;
        rand_keys(win == 0 ? h0 : h1, kq);
        rand_keys(win == 0 ? h1 : h0, kq2);
        session(win, kq, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, RESP_WAIT - 1));
        session(1 - win, kq2, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, RESP_WAIT - 1));
      end else begin
        rand_keys(-1, kq);
        session($urandom_range(0, 1), kq, $urandom_range(0, 3) == 0,
                3'($urandom_range(0, 7)), $urandom_range(0, RESP_WAIT - 1));
      end
    end

    repeat (3) @(negedge clk);
    chk("result_count", n_res, exp_nres);
    chk("handshake_invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/lock_panel_arbiter.md
Name: lock_panel_arbiter

Overview:
- Shares one keypad lock core between two keypad panels (e.g. front and rear door).
- Grants one panel ownership of the lock for a whole entry session: first key through confirm, cancel or inactivity timeout.
- Forwards that panel's key events to the lock as single-cycle strobes.
- Captures the lock's result after confirm and routes it back to the owning panel only.

Parameters:
- TIMEOUT, 1000: idle cycles in a session before it is forcibly cancelled (must be ≥2).
- RESP_WAIT, 3: cycles after the forwarded confirm during which lock result flags are sampled (must be ≥1).

Ports:
- clk  in  1  system clock
- clr  in  1  reset; asynchronous, active-low
- p_vld  in  2  per-panel key valid, bit i = panel i
- p_rdy  out  2  per-panel key ready
- p_key  in  8  per-panel key digit 0-9, panel i at bits [4i+3:4i]
- p_type  in  4  per-panel key type at [2i+1:2i]; 00 digit, 01 confirm '#', 10 cancel '*', 11 reserved
- p_res_vld  out  2  one-cycle result strobe per panel
- p_res_code  out  2  result code, shared, valid with p_res_vld; 00 fail, 01 unlocked, 10 password reset, 11 locked out
- owner  out  1  current/last owner index
- busy  out  1  a session is in progress
- lk_din  out  4  digit to lock
- lk_vld  out  1  digit strobe to lock
- lk_confirm  out  1  confirm strobe to lock
- lk_cancel  out  1  cancel strobe to lock
- lk_unlock_ok  in  1  lock unlock indication
- lk_reset_ok  in  1  lock password-reset indication
- lk_locking  in  1  lock lockout indication

Behaviour:
- Reset (clr low, asynchronous):
  - All outputs 0; owner=0.
  - Round-robin pointer last=1, so panel 0 wins the first tie.
  - State IDLE; counters cleared.
- State IDLE:
  - p_rdy=0, busy=0.
  - If any p_vld is high: grant by round-robin. The panel after last wins a tie; a single requester always wins.
  - owner<=winner, last<=winner, go to OWN next cycle. The request is not consumed in IDLE.
- State OWN:
  - busy=1; p_rdy[owner]=1; p_rdy of the non-owner is 0. The non-owner is back-pressured and its vld/key must be held.
  - Handshake: a key is accepted on p_vld[owner] & p_rdy[owner].
  - Accepted key goes to the lock registered, at cycle t+1; exactly one strobe is high for one cycle.
    - digit: lk_din=key, lk_vld=1. Keys >9 are dropped with no strobe, but still count as activity.
    - confirm: lk_confirm=1; go to WAIT_RES and drop p_rdy in the same cycle.
    - cancel: lk_cancel=1; go to IDLE with no result.
    - type 11: dropped.
  - lk_din holds its last value between strobes; lk_vld/confirm/cancel are 0 otherwise.
  - Inactivity counter: cleared on every accepted key and incremented otherwise. At TIMEOUT-1 it forces lk_cancel=1 for one cycle, then IDLE, with no result to the panel.
- State WAIT_RES:
  - p_rdy=0.
  - Counts RESP_WAIT cycles, starting the cycle after lk_confirm.
  - Sticky-captures any high lock flags during the window.
  - At window end: go to REPORT.
- State REPORT, one cycle:
  - p_res_vld[owner]=1.
  - code priority: locking=11 > reset_ok=10 > unlock_ok=01 > none=00.
  - Then IDLE; the next grant favours the other panel.
- lk_locking high does not block grants. Keys are still forwarded; the lock core enforces lockout and REPORT returns 11.
- Reset mid-session: immediate return to IDLE, no strobe or result emitted, pointer reset.
- Counters are sized $clog2(TIMEOUT) / $clog2(RESP_WAIT+1); they saturate and never wrap.

Decomposition:
- Shared package lock_pkg holds:
  - key type codes KEY_DIGIT/KEY_CONFIRM/KEY_CANCEL;
  - result codes RES_FAIL/RES_UNLOCK/RES_RESET/RES_LOCKED;
  - state enum IDLE/OWN/WAIT_RES/REPORT.
- One sub-module, lock_rr_arb2: a 2-way round-robin picker with last pointer, combinational grant and registered pointer update.
- Session FSM, timers and lock-side strobes live in the top block.

Test Plan:
- Panel 0 keys 1,2,3,4,# with the lock raising unlock_ok 1 cycle after confirm:
  - lk_vld pulses carry 1,2,3,4 on consecutive cycles, then lk_confirm.
  - p_res_vld[0] with code 01; p_res_vld[1] stays 0.
- Both panels assert p_vld in the same cycle from reset:
  - panel 0 owns and p_rdy[1]=0 throughout.
  - After panel 0 sends '#', panel 1 is granted next, and its held keys 6,7,8,9 are forwarded intact.
- Panel 1 sends 6,7,8 then '*':
  - lk_cancel pulses once, no p_res_vld, busy drops, and panel 0 is grantable the next cycle.
- Panel 0 sends 1 then goes idle (TIMEOUT=16):
  - exactly one forced lk_cancel 16 cycles after the last key, no result strobe, then IDLE.
- Confirm with lk_locking and lk_unlock_ok both high in the window -> code 11.
- Confirm with no flags -> code 00.
- Assert clr low while in WAIT_RES:
  - all outputs 0 asynchronously, owner=0.
  - After release, a single request from panel 1 is granted.
